// File: rtl/arith_unit.sv
// Sequential unsigned arithmetic engine: add/sub in one cycle, shift-add multiply
// and restoring divide at one bit per cycle, with a one-cycle done pulse.
module arith_unit #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [1:0]         op,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   Sum,
   output logic               Carry,
   output logic [2*WIDTH-1:0] Product,
   output logic [WIDTH-1:0]   Quotient,
   output logic [WIDTH-1:0]   Remainder,
   output logic               div_by_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [2:0] {IDLE, ADDSUB, MUL, DIV, DONE} state_t;

   state_t             state, state_nxt;
   logic               sub_r;
   logic [WIDTH-1:0]   a_r, b_r;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] prod_r;
   logic [WIDTH-1:0]   rem_r, quo_r;

   logic               accept;
   logic [WIDTH:0]     addsub_res;
   logic [WIDTH-1:0]   mul_add;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic               div_ge;
   logic [WIDTH-1:0]   div_diff;

   assign accept = (state == IDLE) && start;
   assign busy   = (state != IDLE);
   assign done   = (state == DONE);

   // Subtraction is A + ~B + 1, so the carry-out doubles as the "no borrow" flag.
   assign addsub_res = {1'b0, a_r} + {1'b0, (sub_r ? ~b_r : b_r)} + {{WIDTH{1'b0}}, sub_r};

   // prod_r holds {accumulator, multiplier}; the multiplier drains out the bottom.
   assign mul_add = prod_r[0] ? a_r : {WIDTH{1'b0}};
   assign mul_sum = {1'b0, prod_r[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};

   // quo_r starts as the dividend and fills with quotient bits from the right.
   assign div_shift = {rem_r, quo_r[WIDTH-1]};
   assign div_ge    = (div_shift >= {1'b0, b_r});
   assign div_diff  = div_shift[WIDTH-1:0] - b_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) begin
               if (!op[1])        state_nxt = ADDSUB;
               else if (!op[0])   state_nxt = MUL;
               else if (B == '0)  state_nxt = DONE;
               else               state_nxt = DIV;
            end
         end
         ADDSUB:  state_nxt = DONE;
         MUL:     if (cnt == '0) state_nxt = DONE;
         DIV:     if (cnt == '0) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sub_r       <= 1'b0;
         a_r         <= '0;
         b_r         <= '0;
         cnt         <= '0;
         prod_r      <= '0;
         rem_r       <= '0;
         quo_r       <= '0;
         Sum         <= '0;
         Carry       <= 1'b0;
         Product     <= '0;
         Quotient    <= '0;
         Remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         if (accept) begin
            sub_r       <= op[0];
            a_r         <= A;
            b_r         <= B;
            cnt         <= CW'(WIDTH);
            prod_r      <= {{WIDTH{1'b0}}, B};
            rem_r       <= '0;
            quo_r       <= A;
            div_by_zero <= 1'b0;
            // Divide by zero completes straight away, so its results land at accept.
            if (op == 2'b11 && B == '0) begin
               Quotient    <= '1;
               Remainder   <= A;
               div_by_zero <= 1'b1;
            end
         end
         case (state)
            ADDSUB: begin
               Sum   <= addsub_res[WIDTH-1:0];
               Carry <= addsub_res[WIDTH];
            end
            MUL: begin
               if (cnt == '0) begin
                  Product <= prod_r;
               end else begin
                  prod_r <= {mul_sum, prod_r[WIDTH-1:1]};
                  cnt    <= cnt - CW'(1);
               end
            end
            DIV: begin
               if (cnt == '0) begin
                  Quotient  <= quo_r;
                  Remainder <= rem_r;
               end else begin
                  rem_r <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                  quo_r <= {quo_r[WIDTH-2:0], div_ge};
                  cnt   <= cnt - CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_arith_unit.sv
// Directed bench for arith_unit: table of operations with hand-computed results,
// plus sequences for start-while-busy and reset during a multiply.
module tb_arith_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [7:0]  A, B;
   logic        busy, done;
   logic [7:0]  Sum;
   logic        Carry;
   logic [15:0] Product;
   logic [7:0]  Quotient, Remainder;
   logic        div_by_zero;

   int n_cmp = 0;
   int n_bad = 0;

   arith_unit #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
      .busy(busy), .done(done), .Sum(Sum), .Carry(Carry), .Product(Product),
      .Quotient(Quotient), .Remainder(Remainder), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [7:0]  a;
      logic [7:0]  b;
      int          lat;
      logic [7:0]  sum;
      logic        carry;
      logic [15:0] prod;
      logic [7:0]  quo;
      logic [7:0]  rem;
      logic        dbz;
   } vec_t;

   vec_t vecs[11];

   // Held-result model: each op class only refreshes its own outputs.
   logic [7:0]  m_sum, m_quo, m_rem;
   logic        m_carry, m_dbz;
   logic [15:0] m_prod;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Issues one request and returns the cycle count until done (-1 on timeout).
   // Returns at the negedge of the done cycle.
   task automatic do_op(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                        output int lat);
      @(negedge clk);
      start = 1'b1; op = o; A = a; B = b;
      @(negedge clk);
      start = 1'b0; op = ~o; A = ~a; B = b + 8'd3;
      lat = -1;
      for (int n = 1; n <= 40; n++) begin
         if (done) begin
            lat = n;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic check_results(input string tag);
      check({tag, " Sum"},         32'(Sum),         32'(m_sum));
      check({tag, " Carry"},       32'(Carry),       32'(m_carry));
      check({tag, " Product"},     32'(Product),     32'(m_prod));
      check({tag, " Quotient"},    32'(Quotient),    32'(m_quo));
      check({tag, " Remainder"},   32'(Remainder),   32'(m_rem));
      check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(m_dbz));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int ndone;
      vec_t v;

      //           op     a       b     lat sum    c     prod         quo     rem    dbz
      vecs[0]  = '{2'b00, 8'd200, 8'd100, 2, 8'd44,  1'b1, 16'd0,     8'd0,   8'd0,  1'b0};
      vecs[1]  = '{2'b01, 8'd5,   8'd7,   2, 8'd254, 1'b0, 16'd0,     8'd0,   8'd0,  1'b0};
      vecs[2]  = '{2'b01, 8'd7,   8'd7,   2, 8'd0,   1'b1, 16'd0,     8'd0,   8'd0,  1'b0};
      vecs[3]  = '{2'b10, 8'd13,  8'd11, 10, 8'd0,   1'b0, 16'd143,   8'd0,   8'd0,  1'b0};
      vecs[4]  = '{2'b10, 8'd0,   8'd200,10, 8'd0,   1'b0, 16'd0,     8'd0,   8'd0,  1'b0};
      vecs[5]  = '{2'b10, 8'd255, 8'd255,10, 8'd0,   1'b0, 16'd65025, 8'd0,   8'd0,  1'b0};
      vecs[6]  = '{2'b11, 8'd200, 8'd7,  10, 8'd0,   1'b0, 16'd0,     8'd28,  8'd4,  1'b0};
      vecs[7]  = '{2'b11, 8'd5,   8'd9,  10, 8'd0,   1'b0, 16'd0,     8'd0,   8'd5,  1'b0};
      vecs[8]  = '{2'b11, 8'd255, 8'd1,  10, 8'd0,   1'b0, 16'd0,     8'd255, 8'd0,  1'b0};
      vecs[9]  = '{2'b11, 8'd77,  8'd0,   1, 8'd0,   1'b0, 16'd0,     8'd255, 8'd77, 1'b1};
      vecs[10] = '{2'b00, 8'd10,  8'd20,  2, 8'd30,  1'b0, 16'd0,     8'd0,   8'd0,  1'b0};

      m_sum = '0; m_carry = 1'b0; m_prod = '0; m_quo = '0; m_rem = '0; m_dbz = 1'b0;

      rst_n = 1'b0; start = 1'b0; op = 2'b00; A = '0; B = '0;
      repeat (3) @(negedge clk);
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check_results("reset");
      rst_n = 1'b1;

      for (int i = 0; i < 11; i++) begin
         v = vecs[i];
         do_op(v.op, v.a, v.b, lat);
         if (!v.op[1]) begin
            m_sum = v.sum; m_carry = v.carry;
         end else if (!v.op[0]) begin
            m_prod = v.prod;
         end else begin
            m_quo = v.quo; m_rem = v.rem;
         end
         m_dbz = v.dbz;
         check($sformatf("vec%0d latency", i), 32'(lat), 32'(v.lat));
         check($sformatf("vec%0d busy at done", i), 32'(busy), 32'd1);
         check_results($sformatf("vec%0d", i));
         @(negedge clk);
         check($sformatf("vec%0d busy after", i), 32'(busy), 32'd0);
         check($sformatf("vec%0d done after", i), 32'(done), 32'd0);
      end

      // Start pulsed while a multiply is busy must be dropped.
      @(negedge clk);
      start = 1'b1; op = 2'b10; A = 8'd3; B = 8'd4;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      start = 1'b1; op = 2'b00; A = 8'd1; B = 8'd1;
      @(negedge clk);
      start = 1'b0;
      ndone = 0;
      for (int n = 0; n < 20; n++) begin
         if (done) ndone++;
         @(negedge clk);
      end
      m_prod = 16'd12;
      check("busy-start done count", 32'(ndone), 32'd1);
      check("busy-start busy idle", 32'(busy), 32'd0);
      check_results("busy-start");

      // Reset in the 4th multiply cycle abandons the operation.
      start = 1'b1; op = 2'b10; A = 8'd255; B = 8'd255;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid-reset busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int n = 0; n < 15; n++) begin
         if (done) ndone++;
         @(negedge clk);
      end
      m_sum = '0; m_carry = 1'b0; m_prod = '0; m_quo = '0; m_rem = '0; m_dbz = 1'b0;
      check("mid-reset done count", 32'(ndone), 32'd0);
      check_results("mid-reset");
      do_op(2'b00, 8'd1, 8'd1, lat);
      m_sum = 8'd2; m_carry = 1'b0;
      check("post-reset add latency", 32'(lat), 32'd2);
      check_results("post-reset add");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
